if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
- Instruction-fetch stage of the RISC-V pipeline, directly upstream of the instruction ROM.
- Holds the PC and drives the ROM chip-enable and byte address.
- Captures the combinational ROM output (already byte-swapped to instruction order) into a small FIFO of {pc, inst} pairs.
- Presents the FIFO head to the IF/ID boundary with a valid/ready handshake; the FIFO absorbs decode stalls, and a branch/jump redirect flushes it.

Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- QDEPTH, 2: FIFO entries; legal values are 2 or 4 (power of two).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rom_ce  out  1  ROM chip enable (1 = enabled).
- rom_addr  out  32  ROM byte address; always equal to the PC register.
- rom_inst  in  32  ROM instruction, combinational from rom_addr/rom_ce.
- id_valid  out  1  FIFO head holds a valid instruction.
- id_pc  out  32  PC of the head entry.
- id_inst  out  32  instruction of the head entry.
- id_ready  in  1  decode accepts the head this cycle.
- br_valid  in  1  redirect request from EX.
- br_target  in  32  redirect byte address.

Behaviour:
- Reset (asynchronous, dominates every other input):
  - pc = RESET_PC, rom_ce = 0, FIFO count = 0, read/write pointers = 0.
  - id_valid = 0, id_pc = 0, id_inst = 0.
- rom_ce:
  - Registered. The first rising edge after rst deasserts sets it to 1, and it stays 1 until the next rst.
  - While rom_ce = 0, no push occurs.
- Pop:
  - pop = id_valid & id_ready & ~br_valid.
- Push:
  - push = rom_ce & ~br_valid & (count < QDEPTH | pop).
  - A push writes {pc, rom_inst} at the write pointer; on the same edge pc <= pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
  - With no push, pc holds.
- Simultaneous push and pop on a full FIFO: both take effect and count stays QDEPTH.
- Pointers wrap modulo QDEPTH; count is updated as count + push − pop.
- Redirect (br_valid = 1 at an edge):
  - count = 0 and both pointers = 0.
  - pc = {br_target[31:2], 2'b00}, so misaligned low bits are silently cleared.
  - No push or pop occurs that cycle, and an id_ready in the same cycle is ignored.
  - Redirect to head-valid latency: br_valid sampled at edge N, target pushed at edge N+1, id_valid = 1 after edge N+1.
  - Back-to-back redirects: the last one wins.
- Outputs:
  - id_valid = (count != 0).
  - id_pc/id_inst are the head entry when count != 0, else 0.
  - All three come directly from registers; there is no combinational path from rom_inst or id_ready to them.
- Steady state: with id_ready held at 1 and no redirects, one instruction is delivered per cycle.
- Startup latency: rst released before edge 0 -> rom_ce = 1 after edge 0 -> first push at edge 1 -> id_valid = 1, id_pc = RESET_PC after edge 1.
- Stall: with id_ready = 0 the FIFO fills to QDEPTH, then pc freezes. The head entry and its contents stay stable until it is accepted.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for a clock edge, and in-flight entries are discarded.

Test Plan:
- Startup: RESET_PC = 0, ROM word k = 32'h1000_0000 + k, id_ready = 1 -> id_pc sequence 0, 4, 8, ... with id_inst 32'h1000_0000, 32'h1000_0001, ..., valid every cycle from edge 1.
- Stall (QDEPTH = 2): hold id_ready = 0 for 5 cycles after first valid -> count saturates at 2, pc = 8, head stays pc 0. Release -> pcs 0, 4, 8, 12 delivered on consecutive cycles with no gaps or duplicates.
- Redirect: br_valid = 1, br_target = 32'h0000_0043 while the FIFO holds 2 entries -> FIFO empties, id_valid = 0 for one cycle, then id_pc = 32'h40, then 32'h44.
- Redirect + ready: br_valid = 1 and id_ready = 1 on the same edge -> no pop is counted, and the next valid head is the target.
- Wrap: RESET_PC = 32'hFFFF_FFF8 -> id_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Async reset mid-stream: pulse rst between edges -> id_valid, id_pc, id_inst and rom_ce go to 0 immediately. After release, fetch restarts at RESET_PC with the startup latency.

Source files
------------

// File: rtl/if_fetch_queue_if.sv
// Fetch-stage port bundle: ROM request/response, IF/ID handshake, redirect.
// master = fetch stage (drives ROM request and IF/ID head), slave = its environment.
interface if_fetch_queue_if;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_ready;
    logic        br_valid;
    logic [31:0] br_target;

    modport master (
        output rom_ce, rom_addr,
        input  rom_inst,
        output id_valid, id_pc, id_inst,
        input  id_ready,
        input  br_valid, br_target
    );

    modport slave (
        input  rom_ce, rom_addr,
        output rom_inst,
        input  id_valid, id_pc, id_inst,
        output id_ready,
        output br_valid, br_target
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: PC register, ROM request, {pc, inst} FIFO to IF/ID.
// Ports: clk, rst (async, active high), bus (if_fetch_queue_if.master).
module if_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic             clk,
    input  logic             rst,
    if_fetch_queue_if.master bus
);
    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(QDEPTH);

    logic [31:0]   pc_q, pc_d;
    logic          ce_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [31:0]   epc_q   [QDEPTH];
    logic [31:0]   einst_q [QDEPTH];
    logic          head_vld;
    logic          push;
    logic          pop;
    logic          unused_tgt_lo;

    assign unused_tgt_lo = &{1'b0, bus.br_target[1:0]};

    always_comb begin
        head_vld = (cnt_q != '0);
        pop      = head_vld & bus.id_ready & ~bus.br_valid;
        // A full queue can still accept when the head leaves this cycle.
        push     = ce_q & ~bus.br_valid & ((cnt_q < DEPTH) | pop);
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        if (bus.br_valid) begin
            pc_d   = {bus.br_target[31:2], 2'b00};
            cnt_d  = '0;
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push) begin
                pc_d   = pc_q + 32'd4;
                wptr_d = wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PW'(1);
            end
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            ce_q   <= 1'b0;
            cnt_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            pc_q   <= pc_d;
            ce_q   <= 1'b1;
            cnt_q  <= cnt_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QDEPTH; i++) begin
                epc_q[i]   <= '0;
                einst_q[i] <= '0;
            end
        end else if (push) begin
            epc_q[wptr_q]   <= pc_q;
            einst_q[wptr_q] <= bus.rom_inst;
        end
    end

    // Head is a register read gated by occupancy; nothing from rom_inst
    // or id_ready reaches these outputs combinationally.
    assign bus.rom_ce   = ce_q;
    assign bus.rom_addr = pc_q;
    assign bus.id_valid = head_vld;
    assign bus.id_pc    = head_vld ? epc_q[rptr_q] : 32'h0;
    assign bus.id_inst  = head_vld ? einst_q[rptr_q] : 32'h0;
endmodule

// File: tb/tb_if_fetch_queue.sv
// Testbench for if_fetch_queue: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_if_fetch_queue;
    localparam int QD = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;

    logic [63:0] mq[$];
    logic [31:0] m_pc;
    bit          m_ce;

    if_fetch_queue_if bus0 ();
    if_fetch_queue_if bus1 ();

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    assign bus0.rom_inst = rom_word(bus0.rom_addr);
    assign bus1.rom_inst = rom_word(bus1.rom_addr);

    if_fetch_queue #(.RESET_PC(32'h0000_0000), .QDEPTH(QD)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    if_fetch_queue #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(4)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    task automatic model_reset();
        mq.delete();
        m_pc = 32'h0;
        m_ce = 1'b0;
    endtask

    // One rising edge; the model applies the fetch rules to the inputs
    // that were present at that edge.
    task automatic cycle();
        int  n;
        bit  pop;
        bit  push;
        @(posedge clk);
        n = mq.size();
        if (bus0.br_valid) begin
            mq.delete();
            m_pc = {bus0.br_target[31:2], 2'b00};
        end else begin
            pop  = (n != 0) && bus0.id_ready;
            push = m_ce && ((n < QD) || pop);
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back({m_pc, rom_word(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
        m_ce = 1'b1;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        bus0.id_ready = 1'b0; bus0.br_valid = 1'b0; bus0.br_target = '0;
        bus1.id_ready = 1'b1; bus1.br_valid = 1'b0; bus1.br_target = '0;
        #1;
        rst = 1'b1;
        #2;
        checks++; if (bus0.id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus0.id_valid); end
        checks++; if (bus0.id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", bus0.id_pc); end
        checks++; if (bus0.id_inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h want 0", bus0.id_inst); end
        checks++; if (bus0.rom_ce !== 1'b0) begin errors++; $display("FAIL reset_ce got %b want 0", bus0.rom_ce); end
        checks++; if (bus0.rom_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", bus0.rom_addr); end
        checks++; if (bus1.rom_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL reset_addr1 got %h want fffffff8", bus1.rom_addr); end
        @(posedge clk);
        #1;
        checks++; if (bus0.rom_ce !== 1'b0) begin errors++; $display("FAIL reset_hold_ce got %b want 0", bus0.rom_ce); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_startup();
        do_reset();
        bus0.id_ready = 1'b1;
        cycle();
        checks++; if (bus0.rom_ce !== 1'b1) begin errors++; $display("FAIL start_ce got %b want 1", bus0.rom_ce); end
        checks++; if (bus0.id_valid !== 1'b0) begin errors++; $display("FAIL start_valid0 got %b want 0", bus0.id_valid); end
        for (int k = 0; k < 8; k++) begin
            cycle();
            checks++; if (bus0.id_valid !== 1'b1) begin errors++; $display("FAIL start_valid k=%0d got %b want 1", k, bus0.id_valid); end
            checks++; if (bus0.id_pc !== 32'(4 * k)) begin errors++; $display("FAIL start_pc k=%0d got %h want %h", k, bus0.id_pc, 32'(4 * k)); end
            checks++; if (bus0.id_inst !== 32'h1000_0000 + 32'(k)) begin errors++; $display("FAIL start_inst k=%0d got %h want %h", k, bus0.id_inst, 32'h1000_0000 + 32'(k)); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        bus0.id_ready = 1'b0;
        cycle();
        cycle();
        checks++; if (bus0.id_valid !== 1'b1) begin errors++; $display("FAIL stall_first got %b want 1", bus0.id_valid); end
        for (int k = 0; k < 5; k++) begin
            cycle();
            checks++; if (bus0.id_pc !== 32'h0 || bus0.id_inst !== 32'h1000_0000) begin errors++; $display("FAIL stall_head k=%0d got %h/%h want 0/10000000", k, bus0.id_pc, bus0.id_inst); end
        end
        checks++; if (bus0.rom_addr !== 32'h8) begin errors++; $display("FAIL stall_pc got %h want 8", bus0.rom_addr); end
        bus0.id_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (bus0.id_valid !== 1'b1 || bus0.id_pc !== 32'(4 * k)) begin errors++; $display("FAIL stall_drain k=%0d got v=%b pc=%h want v=1 pc=%h", k, bus0.id_valid, bus0.id_pc, 32'(4 * k)); end
            cycle();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        bus0.id_ready = 1'b0;
        cycle();
        cycle();
        cycle();
        checks++; if (bus0.rom_addr !== 32'h8) begin errors++; $display("FAIL redir_full got %h want 8", bus0.rom_addr); end
        bus0.br_valid = 1'b1;
        bus0.br_target = 32'h0000_0043;
        cycle();
        bus0.br_valid = 1'b0;
        checks++; if (bus0.id_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got %b want 0", bus0.id_valid); end
        checks++; if (bus0.rom_addr !== 32'h40) begin errors++; $display("FAIL redir_pc got %h want 40", bus0.rom_addr); end
        bus0.id_ready = 1'b1;
        cycle();
        checks++; if (bus0.id_valid !== 1'b1 || bus0.id_pc !== 32'h40 || bus0.id_inst !== 32'h1000_0010) begin errors++; $display("FAIL redir_head got v=%b %h/%h want 1 40/10000010", bus0.id_valid, bus0.id_pc, bus0.id_inst); end
        cycle();
        checks++; if (bus0.id_pc !== 32'h44 || bus0.id_inst !== 32'h1000_0011) begin errors++; $display("FAIL redir_next got %h/%h want 44/10000011", bus0.id_pc, bus0.id_inst); end
    endtask

    task automatic test_redirect_ready();
        bus0.id_ready = 1'b1;
        bus0.br_valid = 1'b1;
        bus0.br_target = 32'h0000_0200;
        cycle();
        bus0.br_valid = 1'b0;
        checks++; if (bus0.id_valid !== 1'b0) begin errors++; $display("FAIL brrdy_flush got %b want 0", bus0.id_valid); end
        checks++; if (bus0.rom_addr !== 32'h200) begin errors++; $display("FAIL brrdy_pc got %h want 200", bus0.rom_addr); end
        cycle();
        checks++; if (bus0.id_pc !== 32'h200 || bus0.id_inst !== 32'h1000_0080) begin errors++; $display("FAIL brrdy_head got %h/%h want 200/10000080", bus0.id_pc, bus0.id_inst); end
    endtask

    task automatic test_random();
        logic        ev;
        logic [31:0] ep;
        logic [31:0] ei;
        for (int n = 0; n < 400; n++) begin
            bus0.id_ready  = ($urandom_range(9) < 7);
            bus0.br_valid  = ($urandom_range(19) == 0);
            bus0.br_target = $urandom;
            cycle();
            ev = (mq.size() != 0);
            ep = ev ? mq[0][63:32] : 32'h0;
            ei = ev ? mq[0][31:0] : 32'h0;
            checks++; if (bus0.id_valid !== ev || bus0.id_pc !== ep || bus0.id_inst !== ei) begin errors++; $display("FAIL rand_head n=%0d got %b %h/%h want %b %h/%h", n, bus0.id_valid, bus0.id_pc, bus0.id_inst, ev, ep, ei); end
            checks++; if (bus0.rom_addr !== m_pc) begin errors++; $display("FAIL rand_pc n=%0d got %h want %h", n, bus0.rom_addr, m_pc); end
        end
        bus0.br_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        bus0.id_ready = 1'b1;
        cycle();
        cycle();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus0.id_valid !== 1'b0 || bus0.id_pc !== 32'h0 || bus0.id_inst !== 32'h0) begin errors++; $display("FAIL arst_head got %b %h/%h want 0 0/0", bus0.id_valid, bus0.id_pc, bus0.id_inst); end
        checks++; if (bus0.rom_ce !== 1'b0) begin errors++; $display("FAIL arst_ce got %b want 0", bus0.rom_ce); end
        #2;
        rst = 1'b0;
        model_reset();
        cycle();
        checks++; if (bus0.rom_ce !== 1'b1 || bus0.id_valid !== 1'b0) begin errors++; $display("FAIL arst_e0 got ce=%b v=%b want ce=1 v=0", bus0.rom_ce, bus0.id_valid); end
        cycle();
        checks++; if (bus0.id_valid !== 1'b1 || bus0.id_pc !== 32'h0 || bus0.id_inst !== 32'h1000_0000) begin errors++; $display("FAIL arst_e1 got %b %h/%h want 1 0/10000000", bus0.id_valid, bus0.id_pc, bus0.id_inst); end
    endtask

    task automatic test_wrap();
        do_reset();
        bus1.id_ready = 1'b1;
        cycle();
        cycle();
        checks++; if (bus1.id_valid !== 1'b1 || bus1.id_pc !== 32'hFFFF_FFF8 || bus1.id_inst !== 32'h4FFF_FFFE) begin errors++; $display("FAIL wrap_0 got %b %h/%h want 1 fffffff8/4ffffffe", bus1.id_valid, bus1.id_pc, bus1.id_inst); end
        checks++; if (bus1.rom_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr0 got %h want fffffffc", bus1.rom_addr); end
        cycle();
        checks++; if (bus1.id_pc !== 32'hFFFF_FFFC || bus1.id_inst !== 32'h4FFF_FFFF) begin errors++; $display("FAIL wrap_1 got %h/%h want fffffffc/4fffffff", bus1.id_pc, bus1.id_inst); end
        checks++; if (bus1.rom_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr1 got %h want 0", bus1.rom_addr); end
        cycle();
        checks++; if (bus1.id_pc !== 32'h0 || bus1.id_inst !== 32'h1000_0000) begin errors++; $display("FAIL wrap_2 got %h/%h want 0/10000000", bus1.id_pc, bus1.id_inst); end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_stall();
        test_redirect();
        test_redirect_ready();
        test_random();
        test_async_reset();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
